pipe_hazard_ctrl: RTL

- Hazard and sequencing controller for the 16-bit, 5-stage pipeline.
- Drives write-enables, holds and bubble/flush strobes for PC, IF/ID, ID/EX and EX/MEM.
- Handles load-use stalls, taken-branch squash (branch resolved in MEM) and data-memory wait freezes.
- Keeps saturating stall/flush event counters for debug.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_fwd_unit.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned REG_W = 3;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StStall   = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } pipe_state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b01;

  // True when a used source register is produced by a writing stage; r0 never hazards.
  function automatic logic src_hit(logic uses, logic [REG_W-1:0] src, logic wr,
                                   logic [REG_W-1:0] dest);
    return uses && wr && (src != REG_ZERO) && (src == dest);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle. master = pipeline datapath, slave = controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipe_pkg::*;

  logic [REG_W-1:0] id_rs, id_rt;
  logic             id_uses_rs, id_uses_rt;
  logic [REG_W-1:0] ex_dest;
  logic             ex_reg_write, ex_mem_read;
  logic [REG_W-1:0] ex_rs, ex_rt;
  logic [REG_W-1:0] mem_dest;
  logic             mem_reg_write, mem_access;
  logic [REG_W-1:0] wb_dest;
  logic             wb_reg_write;
  logic             branch_taken, dmem_ready;

  logic             pc_write, if_id_write;
  logic             if_id_flush, id_ex_bubble, ex_mem_flush;
  logic             id_ex_hold, ex_mem_hold;
  fwd_sel_t         fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_dest, ex_reg_write, ex_mem_read,
           ex_rs, ex_rt, mem_dest, mem_reg_write, mem_access, wb_dest, wb_reg_write,
           branch_taken, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
           id_ex_hold, ex_mem_hold, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_dest, ex_reg_write, ex_mem_read,
           ex_rs, ex_rt, mem_dest, mem_reg_write, mem_access, wb_dest, wb_reg_write,
           branch_taken, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
           id_ex_hold, ex_mem_hold, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_fwd_unit.sv
// ALU operand forwarding compare for one EX source; EX/MEM wins over MEM/WB.
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] ex_src,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_reg_write,
  output fwd_sel_t         fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (src_hit(1'b1, ex_src, mem_reg_write, mem_dest)) begin
      fwd = FWD_MEM;
    end else if (src_hit(1'b1, ex_src, wb_reg_write, wb_dest)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, branch squash, dmem freeze, event counters.
// Optional operand forwarding is enabled with the PIPE_FORWARDING_EN macro.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             memwait, hazard;

  assign memwait = bus.mem_access & ~bus.dmem_ready;

`ifdef PIPE_FORWARDING_EN
  fwd_sel_t fwd_a_raw, fwd_b_raw;

  // Only a load in EX cannot be forwarded in time.
  assign hazard = bus.ex_mem_read &
                  (src_hit(bus.id_uses_rs, bus.id_rs, bus.ex_reg_write, bus.ex_dest) |
                   src_hit(bus.id_uses_rt, bus.id_rt, bus.ex_reg_write, bus.ex_dest));

  pipe_fwd_unit u_fwd_a (
    .ex_src        (bus.ex_rs),
    .mem_dest      (bus.mem_dest),
    .mem_reg_write (bus.mem_reg_write),
    .wb_dest       (bus.wb_dest),
    .wb_reg_write  (bus.wb_reg_write),
    .fwd           (fwd_a_raw)
  );

  pipe_fwd_unit u_fwd_b (
    .ex_src        (bus.ex_rt),
    .mem_dest      (bus.mem_dest),
    .mem_reg_write (bus.mem_reg_write),
    .wb_dest       (bus.wb_dest),
    .wb_reg_write  (bus.wb_reg_write),
    .fwd           (fwd_b_raw)
  );

  assign bus.fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign bus.fwd_b = rst ? FWD_RF : fwd_b_raw;
`else
  logic unused_fwd_inputs;

  assign hazard = src_hit(bus.id_uses_rs, bus.id_rs, bus.ex_reg_write, bus.ex_dest)   |
                  src_hit(bus.id_uses_rs, bus.id_rs, bus.mem_reg_write, bus.mem_dest) |
                  src_hit(bus.id_uses_rt, bus.id_rt, bus.ex_reg_write, bus.ex_dest)   |
                  src_hit(bus.id_uses_rt, bus.id_rt, bus.mem_reg_write, bus.mem_dest);

  assign unused_fwd_inputs = ^{bus.ex_rs, bus.ex_rt, bus.wb_dest, bus.wb_reg_write,
                               bus.ex_mem_read};
  assign bus.fwd_a = FWD_RF;
  assign bus.fwd_b = FWD_RF;
`endif

  always_comb begin
    state_d = StRun;
    if (memwait) begin
      state_d = StMemWait;
    end else if (bus.branch_taken) begin
      state_d = StFlush;
    end else if (hazard) begin
      state_d = StStall;
    end
  end

  always_comb begin
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.id_ex_hold   = 1'b0;
    bus.ex_mem_hold  = 1'b0;
    if (rst) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else begin
      unique case (state_d)
        StRun: begin
          bus.pc_write    = 1'b1;
          bus.if_id_write = 1'b1;
        end
        StStall: begin
          bus.id_ex_bubble = 1'b1;
        end
        StMemWait: begin
          bus.id_ex_hold  = 1'b1;
          bus.ex_mem_hold = 1'b1;
        end
        StFlush: begin
          bus.pc_write     = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.id_ex_bubble = 1'b1;
          bus.ex_mem_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StStall && stall_cnt_q != CntMax) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (state_d == StFlush && flush_cnt_q != CntMax) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  // Entering STALL/FLUSH always bumps (or keeps saturated) its counter.
  stall_cnt_live: assert property (@(posedge clk) disable iff (rst)
    (state_q == StStall) |-> (stall_cnt_q != '0));
  flush_cnt_live: assert property (@(posedge clk) disable iff (rst)
    (state_q == StFlush) |-> (flush_cnt_q != '0));

endmodule
